vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_pix_div.sv | 38 +++
 rtl/vga_sync_gen.sv | 91 +++++++++
 tb/tb_vga_sync_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and small decode helpers.
package vga_pkg;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned CLK_DIV_DEF = 4;

    localparam int unsigned H_VIS_DEF   = 640;
    localparam int unsigned H_FP_DEF    = 16;
    localparam int unsigned H_SYNC_DEF  = 96;
    localparam int unsigned H_BP_DEF    = 48;

    localparam int unsigned V_VIS_DEF   = 480;
    localparam int unsigned V_FP_DEF    = 10;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BP_DEF    = 33;

    localparam int unsigned H_TOTAL      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned H_SYNC_START = H_VIS_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START = V_VIS_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    // True when a counter value lies inside the inclusive window [lo, hi].
    function automatic logic in_window(input logic [CNT_W-1:0] v,
                                       input int unsigned lo,
                                       input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one-clk pix_en strobe every CLK_DIV system clocks.
module vga_pix_div
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;

    // Strobe is decoded from the next divider value so it lines up with div==CLK_DIV-1.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q >= DIV_W'(CLK_DIV - 1)) begin
            div_d = '0;
        end
        pix_en_d = (div_d == DIV_W'(CLK_DIV - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
        end
    end

    assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters with registered sync, blank and frame-event outputs.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned H_VIS   = H_VIS_DEF,
    parameter int unsigned H_FP    = H_FP_DEF,
    parameter int unsigned H_SYNC  = H_SYNC_DEF,
    parameter int unsigned H_BP    = H_BP_DEF,
    parameter int unsigned V_VIS   = V_VIS_DEF,
    parameter int unsigned V_FP    = V_FP_DEF,
    parameter int unsigned V_SYNC  = V_SYNC_DEF,
    parameter int unsigned V_BP    = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             HS,
    output logic             VS,
    output logic             blank,
    output logic             frame_tick
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_LO = H_VIS + H_FP;
    localparam int unsigned HS_HI = HS_LO + H_SYNC - 1;
    localparam int unsigned VS_LO = V_VIS + V_FP;
    localparam int unsigned VS_HI = VS_LO + V_SYNC - 1;

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             blank_q, blank_d, frame_tick_q, frame_tick_d;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    // Next raster position; >= compares keep the counters in range even from a bad state.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (32'(x_q) >= H_TOT - 1) begin
                x_d = '0;
                if (32'(y_q) >= V_TOT - 1) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + CNT_W'(1);
                end
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end

        hs_d         = ~in_window(x_d, HS_LO, HS_HI);
        vs_d         = ~in_window(y_d, VS_LO, VS_HI);
        blank_d      = (32'(x_d) >= H_VIS) || (32'(y_d) >= V_VIS);
        frame_tick_d = pix_en && (x_d == '0) && (32'(y_d) == V_VIS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blank_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign HS         = hs_q;
    assign VS         = vs_q;
    assign blank      = blank_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunk-timing instance for full frames, a default one for line timing.
module tb_vga_sync_gen;

    localparam longint SCD = 2;
    localparam longint SHV = 16, SHF = 2, SHS = 3, SHB = 3;
    localparam longint SVV = 10, SVF = 2, SVS = 2, SVB = 3;

    typedef struct packed {
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ft;
    } obs_t;

    typedef struct {
        longint n;
        obs_t   exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_s, rst_d;
    logic       pe_s, hs_s, vs_s, bl_s, ft_s;
    logic       pe_d, hs_d, vs_d, bl_d, ft_d;
    logic [9:0] x_s, y_s, x_d, y_d;
    longint     n_s, n_d;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV(SCD),
        .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (
        .clk(clk), .rst(rst_s), .pix_en(pe_s), .x(x_s), .y(y_s),
        .HS(hs_s), .VS(vs_s), .blank(bl_s), .frame_tick(ft_s)
    );

    vga_sync_gen u_dflt (
        .clk(clk), .rst(rst_d), .pix_en(pe_d), .x(x_d), .y(y_d),
        .HS(hs_d), .VS(vs_d), .blank(bl_d), .frame_tick(ft_d)
    );

    obs_t obs_s, obs_d;
    assign obs_s = {pe_s, x_s, y_s, hs_s, vs_s, bl_s, ft_s};
    assign obs_d = {pe_d, x_d, y_d, hs_d, vs_d, bl_d, ft_d};

    function automatic obs_t mk(input logic pe, input int xv, input int yv,
                                input logic hs, input logic vs, input logic bl, input logic ft);
        obs_t o;
        o.pe = pe; o.x = 10'(xv); o.y = 10'(yv);
        o.hs = hs; o.vs = vs; o.bl = bl; o.ft = ft;
        return o;
    endfunction

    // Outputs after n rising edges since reset release, from pixel index n/cd.
    function automatic obs_t model(input longint n, input longint cd,
                                   input longint hv, input longint hf, input longint hsn, input longint hb,
                                   input longint vv, input longint vf, input longint vsn, input longint vb);
        longint ht, vt, p, px, py;
        obs_t   m;
        ht   = hv + hf + hsn + hb;
        vt   = vv + vf + vsn + vb;
        p    = n / cd;
        px   = p % ht;
        py   = (p / ht) % vt;
        m.pe = ((n % cd) == cd - 1);
        m.x  = 10'(px);
        m.y  = 10'(py);
        m.hs = !((px >= hv + hf) && (px < hv + hf + hsn));
        m.vs = !((py >= vv + vf) && (py < vv + vf + vsn));
        m.bl = (px >= hv) || (py >= vv);
        m.ft = (n > 0) && ((n % cd) == 0) && (px == 0) && (py == vv);
        return m;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got pe=%0b x=%0d y=%0d hs=%0b vs=%0b blank=%0b ft=%0b, expected pe=%0b x=%0d y=%0d hs=%0b vs=%0b blank=%0b ft=%0b",
                     name, got.pe, got.x, got.y, got.hs, got.vs, got.bl, got.ft,
                     exp.pe, exp.x, exp.y, exp.hs, exp.vs, exp.bl, exp.ft);
        end
    endtask

    task automatic check_int(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        if (!rst_s) n_s++;
        if (!rst_d) n_d++;
        @(negedge clk);
    endtask

    vec_t tbl[12];
    obs_t rst_val;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        longint first_pe, first_x1, hs_low, hs_start, x_at_hs, line_end, pe_cnt;
        int     len;

        rst_val = mk(0, 0, 0, 1, 1, 0, 0);
        tbl[0]  = '{0,   mk(0, 0,  0,  1, 1, 0, 0)};
        tbl[1]  = '{1,   mk(1, 0,  0,  1, 1, 0, 0)};
        tbl[2]  = '{2,   mk(0, 1,  0,  1, 1, 0, 0)};
        tbl[3]  = '{36,  mk(0, 18, 0,  0, 1, 1, 0)};
        tbl[4]  = '{41,  mk(1, 20, 0,  0, 1, 1, 0)};
        tbl[5]  = '{42,  mk(0, 21, 0,  1, 1, 1, 0)};
        tbl[6]  = '{48,  mk(0, 0,  1,  1, 1, 0, 0)};
        tbl[7]  = '{480, mk(0, 0,  10, 1, 1, 1, 1)};
        tbl[8]  = '{481, mk(1, 0,  10, 1, 1, 1, 0)};
        tbl[9]  = '{576, mk(0, 0,  12, 1, 0, 1, 0)};
        tbl[10] = '{815, mk(1, 23, 16, 1, 1, 1, 0)};
        tbl[11] = '{816, mk(0, 0,  0,  1, 1, 0, 0)};

        rst_s = 1'b1; rst_d = 1'b1; n_s = 0; n_d = 0;
        repeat (2) @(negedge clk);
        check("reset_small", obs_s, rst_val);
        check("reset_default", obs_d, rst_val);

        // Hand-derived vectors on the shrunk raster, including the frame wrap.
        rst_s = 1'b0;
        for (int i = 0; i < 12; i++) begin
            while (n_s < tbl[i].n) tick();
            check($sformatf("vec%0d", i), obs_s, tbl[i].exp);
        end

        // Random run lengths against the model, each ended by an async mid-cycle reset.
        for (int r = 0; r < 4; r++) begin
            rst_s = 1'b1; n_s = 0;
            repeat ($urandom_range(1, 3)) tick();
            rst_s = 1'b0;
            len = (r == 0) ? 1800 : int'($urandom_range(300, 1500));
            for (int k = 0; k < len; k++) begin
                tick();
                check("rand_small", obs_s, model(n_s, SCD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB));
            end
            #2 rst_s = 1'b1; n_s = 0;
            #1 check("async_rst_small", obs_s, rst_val);
            @(negedge clk);
        end
        rst_s = 1'b0;

        // Default timing: divider start-up and one full line.
        rst_d = 1'b0; n_d = 0;
        first_pe = -1; first_x1 = -1; hs_low = 0; hs_start = -1; x_at_hs = -1;
        line_end = -1; pe_cnt = 0;
        for (int k = 0; k < 3200; k++) begin
            tick();
            if (pe_d) pe_cnt++;
            if (pe_d && first_pe < 0) first_pe = n_d;
            if (x_d == 10'd1 && first_x1 < 0) first_x1 = n_d;
            if (!hs_d) begin
                hs_low++;
                if (hs_start < 0) begin hs_start = n_d; x_at_hs = longint'(x_d); end
            end
            if (x_d == 10'd0 && y_d == 10'd1 && line_end < 0) line_end = n_d;
        end
        check_int("first_pix_en_edge", first_pe, 3);
        check_int("x1_edge", first_x1, 4);
        check_int("pix_en_per_line", pe_cnt, 800);
        check_int("hs_low_clks", hs_low, 384);
        check_int("hs_start_edge", hs_start, 2624);
        check_int("hs_start_x", x_at_hs, 656);
        check_int("line_period", line_end, 3200);

        // Async reset mid-line on the default instance, then restart.
        rst_d = 1'b1; tick(); n_d = 0; rst_d = 1'b0;
        while (n_d < 1200) tick();
        check("x300_default", obs_d, model(n_d, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        #2 rst_d = 1'b1;
        #1 check("async_rst_default", obs_d, rst_val);
        @(negedge clk);
        rst_d = 1'b0; n_d = 0;
        first_pe = -1; first_x1 = -1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (pe_d && first_pe < 0) first_pe = n_d;
            if (x_d == 10'd1 && first_x1 < 0) first_x1 = n_d;
        end
        check_int("restart_pix_en_edge", first_pe, 3);
        check_int("restart_x1_edge", first_x1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
